// File: rtl/drive_arbiter.sv
// drive_arbiter: track debounce, obstacle hysteresis and follow/halt/search FSM.
// Optional DRIVE_STATUS_EN adds status and halt_cnt outputs.
module drive_arbiter #(
  parameter int DEB_CYCLES    = 100000,
  parameter int START_CYCLES  = 5000000,
  parameter int SEARCH_CYCLES = 50000000,
  parameter int STOP_CM       = 15,
  parameter int GO_CM         = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        left_track,
  input  logic        mid_track,
  input  logic        right_track,
  input  logic [19:0] distance,
  output logic [1:0]  mode
`ifdef DRIVE_STATUS_EN
  ,
  output logic [2:0]  status,
  output logic [7:0]  halt_cnt
`endif
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(START_CYCLES + 1);
  localparam int SW = $clog2(SEARCH_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST  = TW'(START_CYCLES - 1);
  localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_CYCLES - 1);

  localparam logic [19:0] STOP_D = 20'(STOP_CM);
  localparam logic [19:0] GO_D   = 20'(GO_CM);

  localparam logic [1:0] M_STOP  = 2'b00;
  localparam logic [1:0] M_LEFT  = 2'b01;
  localparam logic [1:0] M_RIGHT = 2'b10;
  localparam logic [1:0] M_FWD   = 2'b11;

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FOLLOW = 3'd1,
    S_HALT   = 3'd2,
    S_SEARCH = 3'd3,
    S_LOST   = 3'd4
  } state_t;

  logic [2:0]    w_raw;
  logic [2:0]    r_filt;
  logic [DW-1:0] r_deb_cnt [3];

  logic          r_obst;
  logic          w_obst_set;
  logic          w_obst_clr;
  logic          r_last_right;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_mode;
  logic [1:0]    w_mode_nxt;
  logic [TW-1:0] r_start_cnt;
  logic [TW-1:0] w_start_nxt;
  logic [SW-1:0] r_search_cnt;
  logic [SW-1:0] w_search_nxt;

  assign w_raw = {left_track, mid_track, right_track};

  function automatic logic [1:0] f_decode(input logic [2:0] lmr);
    logic [1:0] m;
    m = M_STOP;
    unique case (lmr)
      3'b010, 3'b111, 3'b101: m = M_FWD;
      3'b100, 3'b110:         m = M_LEFT;
      3'b001, 3'b011:         m = M_RIGHT;
      default:                m = M_STOP;
    endcase
    return m;
  endfunction

  // Per-sensor debounce: accept raw after DEB_CYCLES consecutive differing cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= '0;
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_raw[i] == r_filt[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] >= DEB_LAST) begin
          r_filt[i]    <= w_raw[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Obstacle thresholds; distance 0 means no echo and never sets the flag
  assign w_obst_set = (distance != '0) && (distance < STOP_D);
  assign w_obst_clr = (distance >= GO_D);

  // Obstacle flag with hysteresis between STOP_CM and GO_CM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_obst <= 1'b0;
    end else if (w_obst_set) begin
      r_obst <= 1'b1;
    end else if (w_obst_clr) begin
      r_obst <= 1'b0;
    end
  end

  // Remember which outer sensor last saw the line alone
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_right <= 1'b0;
    end else if (r_filt[2] && !r_filt[0]) begin
      r_last_right <= 1'b0;
    end else if (!r_filt[2] && r_filt[0]) begin
      r_last_right <= 1'b1;
    end
  end

  // Next state, counters and the mode that accompanies the next state
  always_comb begin
    w_state_nxt  = r_state;
    w_start_nxt  = r_start_cnt;
    w_search_nxt = r_search_cnt;
    w_mode_nxt   = M_STOP;
    unique case (r_state)
      S_START: begin
        if (r_start_cnt >= START_LAST) begin
          w_state_nxt = S_FOLLOW;
        end else begin
          w_start_nxt = r_start_cnt + 1'b1;
        end
      end
      S_FOLLOW: begin
        if (r_obst) begin
          w_state_nxt = S_HALT;
        end else if (r_filt == 3'b000) begin
          w_state_nxt  = S_SEARCH;
          w_search_nxt = '0;
        end
      end
      S_HALT: begin
        if (!r_obst) w_state_nxt = S_FOLLOW;
      end
      S_SEARCH: begin
        if (r_obst) begin
          w_state_nxt = S_HALT;
        end else if (|r_filt) begin
          w_state_nxt = S_FOLLOW;
        end else if (r_search_cnt >= SEARCH_LAST) begin
          w_state_nxt = S_LOST;
        end else begin
          w_search_nxt = r_search_cnt + 1'b1;
        end
      end
      S_LOST: begin
        if (|r_filt) w_state_nxt = S_FOLLOW;
      end
      default: w_state_nxt = S_START;
    endcase
    unique case (w_state_nxt)
      S_FOLLOW: w_mode_nxt = f_decode(r_filt);
      S_SEARCH: w_mode_nxt = r_last_right ? M_RIGHT : M_LEFT;
      default:  w_mode_nxt = M_STOP;
    endcase
  end

  // State, mode and timers are registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_START;
      r_mode       <= M_STOP;
      r_start_cnt  <= '0;
      r_search_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode       <= w_mode_nxt;
      r_start_cnt  <= w_start_nxt;
      r_search_cnt <= w_search_nxt;
    end
  end

  assign mode = r_mode;

`ifdef DRIVE_STATUS_EN
  logic [7:0] r_halt_cnt;

  // Count entries into HALT, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halt_cnt <= '0;
    end else if (w_state_nxt == S_HALT && r_state != S_HALT
                 && r_halt_cnt != 8'hFF) begin
      r_halt_cnt <= r_halt_cnt + 8'd1;
    end
  end

  assign status   = r_state;
  assign halt_cnt = r_halt_cnt;
`endif

endmodule

// File: tb/tb_drive_arbiter.sv
// tb_drive_arbiter: directed vectors for drive_arbiter with small timing params.
// Covers start, debounce, obstacle hysteresis, search/lost and reset.
module tb_drive_arbiter;

  logic        clk;
  logic        rst;
  logic        left_track;
  logic        mid_track;
  logic        right_track;
  logic [19:0] distance;
  logic [1:0]  mode;
`ifdef DRIVE_STATUS_EN
  logic [2:0]  status;
  logic [7:0]  halt_cnt;
`endif

  int n_chk;
  int n_err;

  drive_arbiter #(
    .DEB_CYCLES   (4),
    .START_CYCLES (8),
    .SEARCH_CYCLES(16),
    .STOP_CM      (15),
    .GO_CM        (20)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .left_track (left_track),
    .mid_track  (mid_track),
    .right_track(right_track),
    .distance   (distance),
    .mode       (mode)
`ifdef DRIVE_STATUS_EN
    ,
    .status     (status),
    .halt_cnt   (halt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lmr(input logic [2:0] v);
    left_track  = v[2];
    mid_track   = v[1];
    right_track = v[0];
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;

    rst = 1'b1;
    set_lmr(3'b010);
    distance = 20'd100;
    tick();
    tick();
    chk("rst_mode", {6'd0, mode}, 8'd0);
`ifdef DRIVE_STATUS_EN
    chk("rst_status", {5'd0, status}, 8'd0);
    chk("rst_halt_cnt", halt_cnt, 8'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("start_stop", {6'd0, mode}, 8'd0);
    end
    tick();
    chk("start_fwd", {6'd0, mode}, 8'd3);
`ifdef DRIVE_STATUS_EN
    chk("follow_status", {5'd0, status}, 8'd1);
`endif

    set_lmr(3'b100);
    repeat (4) tick();
    chk("left_deb", {6'd0, mode}, 8'd3);
    tick();
    chk("left_turn", {6'd0, mode}, 8'd1);
    set_lmr(3'b010);
    repeat (5) tick();
    chk("fwd_again", {6'd0, mode}, 8'd3);
    set_lmr(3'b001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("glitch", {6'd0, mode}, 8'd3);
    end
    set_lmr(3'b010);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("glitch_after", {6'd0, mode}, 8'd3);
    end

    distance = 20'd15;
    repeat (3) tick();
    chk("d15_no_obst", {6'd0, mode}, 8'd3);
    distance = 20'd0;
    repeat (3) tick();
    chk("d0_no_obst", {6'd0, mode}, 8'd3);
    distance = 20'd14;
    tick();
    chk("obst_latency", {6'd0, mode}, 8'd3);
    tick();
    chk("halt_d14", {6'd0, mode}, 8'd0);
    distance = 20'd16;
    repeat (3) tick();
    chk("halt_d16", {6'd0, mode}, 8'd0);
    distance = 20'd19;
    repeat (3) tick();
    chk("halt_d19", {6'd0, mode}, 8'd0);
    distance = 20'd20;
    tick();
    chk("clear_latency", {6'd0, mode}, 8'd0);
    tick();
    chk("go_d20", {6'd0, mode}, 8'd3);
    distance = 20'd14;
    repeat (2) tick();
    chk("halt_again", {6'd0, mode}, 8'd0);
    distance = 20'd0;
    repeat (4) tick();
    chk("halt_d0", {6'd0, mode}, 8'd0);
    distance = 20'd100;
    repeat (2) tick();
    chk("go_d100", {6'd0, mode}, 8'd3);
`ifdef DRIVE_STATUS_EN
    chk("halt_cnt2", halt_cnt, 8'd2);
`endif

    set_lmr(3'b001);
    repeat (4) tick();
    chk("right_deb", {6'd0, mode}, 8'd3);
    tick();
    chk("right_turn", {6'd0, mode}, 8'd2);
    set_lmr(3'b000);
    repeat (4) tick();
    chk("pre_search", {6'd0, mode}, 8'd2);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("search_right", {6'd0, mode}, 8'd2);
    end
    tick();
    chk("lost", {6'd0, mode}, 8'd0);
`ifdef DRIVE_STATUS_EN
    chk("lost_status", {5'd0, status}, 8'd4);
`endif
    repeat (3) tick();
    chk("lost_hold", {6'd0, mode}, 8'd0);
    set_lmr(3'b010);
    repeat (4) tick();
    chk("lost_deb", {6'd0, mode}, 8'd0);
    tick();
    chk("reacquire", {6'd0, mode}, 8'd3);

    set_lmr(3'b000);
    repeat (4) tick();
    chk("pre_search2", {6'd0, mode}, 8'd3);
    tick();
    chk("search2", {6'd0, mode}, 8'd2);
    set_lmr(3'b010);
    repeat (3) tick();
    chk("search_keep", {6'd0, mode}, 8'd2);
    distance = 20'd10;
    tick();
    chk("search_edge", {6'd0, mode}, 8'd2);
    tick();
    chk("obst_wins", {6'd0, mode}, 8'd0);
`ifdef DRIVE_STATUS_EN
    chk("obst_wins_status", {5'd0, status}, 8'd2);
`endif
    distance = 20'd100;
    tick();
    chk("unhalt_lat", {6'd0, mode}, 8'd0);
    tick();
    chk("unhalt", {6'd0, mode}, 8'd3);

    set_lmr(3'b000);
    repeat (5) tick();
    chk("search3", {6'd0, mode}, 8'd2);
    repeat (2) tick();
`ifdef DRIVE_STATUS_EN
    chk("halt_cnt3", halt_cnt, 8'd3);
`endif
    rst = 1'b1;
    tick();
    chk("rst_mid_mode", {6'd0, mode}, 8'd0);
`ifdef DRIVE_STATUS_EN
    chk("rst_mid_status", {5'd0, status}, 8'd0);
    chk("rst_mid_halt_cnt", halt_cnt, 8'd0);
`endif
    rst = 1'b0;
    set_lmr(3'b010);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("restart_stop", {6'd0, mode}, 8'd0);
    end
    tick();
    chk("restart_fwd", {6'd0, mode}, 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
